exception_arbiter: RTL and testbench
====================================

EXCEPTION_ARBITER -- requirements
Module: exception_arbiter

Interface
REQ-001 Parameter NIRQ, default 4, number of maskable IRQ channels (1..16).
REQ-002 Parameter VECW, default 8, width of PCVectorAddress; SHALL hold 0x20+4*(NIRQ-1).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 UndefinedInstrE, SWIE, PrefetchAbortE  in  1 each  synchronous exceptions detected in E.
REQ-006 DataAbort  in  1  data abort detected in M.
REQ-007 FIQ, FIQEnabled  in  1 each  fast interrupt request / enable.
REQ-008 IrqReq, IrqEnable  in  NIRQ each  level IRQ requests / per-channel enables.
REQ-009 PipelineClearD, PipelineClearM  in  1 each  drain marker present in D / M.
REQ-010 PipelineClearF  out  1  inject drain marker into F.
REQ-011 ExceptionFlushD, ExceptionFlushE, ExceptionFlushM, ExceptionFlushW, ExceptionStallD  out  1 each  pipeline controls.
REQ-012 DataAbortCycle2, FIQAssert  out  1 each  second abort cycle / FIQ taken pulse.
REQ-013 IrqAck  out  NIRQ  one-hot pulse, channel taken.
REQ-014 PCVectorAddress  out  VECW  vector offset; ExceptionSavePC, PCInSelect, ExceptionResetMicrop  out  1 each.
REQ-015 Busy  out  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, ABORT2, DRAIN, TAKE; reset and all state registers SHALL use the async active-low reset.
REQ-017 Priority SHALL be DataAbort > PrefetchAbortE > UndefinedInstrE > SWIE > FIQ&FIQEnabled > IrqReq[0]&IrqEnable[0] > ... > IrqReq[NIRQ-1].
REQ-018 DataAbort in any state: same cycle FlushD/M/W=1, FlushE=1, StallD=1, ExceptionResetMicrop=1; next state ABORT2, discarding any drain.
REQ-019 ABORT2: DataAbortCycle2=1, FlushD/M/W=1, FlushE=0, StallD=0, ExceptionSavePC=1, PCInSelect=1, vector 0x10; next IDLE.
REQ-020 Synchronous exception (no DataAbort), any state except ABORT2: same cycle FlushD=1, FlushM=1, FlushE=FlushW=0, SavePC=1, PCInSelect=1, vector 0x0C/0x04/0x08 (prefetch/undef/SWI); next IDLE, drain discarded.
REQ-021 IDLE with eligible FIQ/IRQ and no higher event: latch target (FIQ or lowest-index IRQ) and go DRAIN; PipelineClearF=1 this cycle.
REQ-022 DRAIN: PipelineClearF=1 while PipelineClearM=0; FlushE=StallD=PipelineClearD&~PipelineClearM; PipelineClearM=1 -> TAKE.
REQ-023 DRAIN: newly eligible FIQ SHALL replace a latched IRQ target; IRQs never replace a latched target.
REQ-024 DRAIN: if latched target is no longer eligible (request dropped or masked), return to IDLE with no ack, PipelineClearF=0.
REQ-025 TAKE (one cycle): FlushD=1, SavePC=1, PCInSelect=0; FIQAssert=1 with vector 0x1C, or IrqAck[k]=1 with vector 0x20+4k; next IDLE.
REQ-026 Acks SHALL be single-cycle pulses, at most one bit of {FIQAssert, IrqAck} high per cycle.
REQ-027 PCVectorAddress SHALL be 0 whenever ExceptionSavePC=0; ExceptionSavePC SHALL equal OR of all taken-event signals.
REQ-028 Outputs not specified for a state SHALL be 0.

Reset
REQ-029 While reset=0: state IDLE, latched target cleared, every output 0.
REQ-030 Reset asserted mid-DRAIN or ABORT2 SHALL abandon the operation; no ack after release.
REQ-031 First cycle after release SHALL behave as IDLE.

Verification
REQ-032 DataAbort pulse 1 cycle -> cycle0 FlushE/StallD/ResetMicrop=1; cycle1 DataAbortCycle2=1, SavePC=1, PCVectorAddress=0x10.
REQ-033 IrqReq=4'b0110, all enabled -> DRAIN, PipelineClearF until PipelineClearM=1, then IrqAck=4'b0010, vector 0x24, FlushD=1.
REQ-034 IRQ2 draining, FIQ&FIQEnabled raised -> TAKE asserts FIQAssert, vector 0x1C, IrqAck=0.
REQ-035 DRAIN with SWIE=1 -> vector 0x08, PCInSelect=1, state IDLE, no ack; IRQ still high -> new drain starts.
REQ-036 DataAbort and UndefinedInstrE same cycle -> abort sequence only, vector 0x10 in cycle1.
REQ-037 reset=0 during DRAIN -> all outputs 0 immediately; after release with no requests, Busy=0 and no ack.

Source files
------------

// File: rtl/exception_arbiter.sv
// Exception/interrupt arbiter: prioritises aborts, synchronous exceptions, FIQ and IRQs,
// drains the pipeline before taking an interrupt and produces flush/stall/vector controls.
module exception_arbiter #(
  parameter int NIRQ = 4,
  parameter int VECW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            UndefinedInstrE,
  input  logic            SWIE,
  input  logic            PrefetchAbortE,
  input  logic            DataAbort,
  input  logic            FIQ,
  input  logic            FIQEnabled,
  input  logic [NIRQ-1:0] IrqReq,
  input  logic [NIRQ-1:0] IrqEnable,
  input  logic            PipelineClearD,
  input  logic            PipelineClearM,
  output logic            PipelineClearF,
  output logic            ExceptionFlushD,
  output logic            ExceptionFlushE,
  output logic            ExceptionFlushM,
  output logic            ExceptionFlushW,
  output logic            ExceptionStallD,
  output logic            DataAbortCycle2,
  output logic            FIQAssert,
  output logic [NIRQ-1:0] IrqAck,
  output logic [VECW-1:0] PCVectorAddress,
  output logic            ExceptionSavePC,
  output logic            PCInSelect,
  output logic            ExceptionResetMicrop,
  output logic            Busy
);

  localparam int IDXW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ABORT2 = 2'b01,
    S_DRAIN  = 2'b10,
    S_TAKE   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              tgt_fiq_q, tgt_fiq_d;
  logic [IDXW-1:0]   tgt_irq_q, tgt_irq_d;

  logic              fiq_el_s;
  logic [NIRQ-1:0]   irq_el_s;
  logic              irq_any_s;
  logic [IDXW-1:0]   irq_idx_s;
  logic              sync_s;
  logic [VECW-1:0]   sync_vec_s;
  logic              tgt_ok_s;

  logic              clr_f_s, fl_d_s, fl_e_s, fl_m_s, fl_w_s, stall_s;
  logic              cyc2_s, fiq_a_s, save_s, pcin_s, rmicro_s;
  logic [NIRQ-1:0]   ack_s;
  logic [VECW-1:0]   vec_s;

  // Eligible requests, lowest-index IRQ and the highest synchronous exception.
  always_comb begin
    fiq_el_s  = FIQ & FIQEnabled;
    irq_el_s  = IrqReq & IrqEnable;
    irq_any_s = |irq_el_s;
    irq_idx_s = {IDXW{1'b0}};
    for (int i = NIRQ - 1; i >= 0; i--) begin
      irq_idx_s = irq_el_s[i] ? IDXW'(i) : irq_idx_s;
    end
    sync_s = PrefetchAbortE | UndefinedInstrE | SWIE;
    if (PrefetchAbortE) begin
      sync_vec_s = VECW'(8'h0C);
    end else if (UndefinedInstrE) begin
      sync_vec_s = VECW'(8'h04);
    end else begin
      sync_vec_s = VECW'(8'h08);
    end
  end

  // Next state, target latch and all pipeline controls.
  always_comb begin
    state_d   = state_q;
    tgt_fiq_d = tgt_fiq_q;
    tgt_irq_d = tgt_irq_q;
    clr_f_s = 1'b0; fl_d_s = 1'b0; fl_e_s = 1'b0; fl_m_s = 1'b0; fl_w_s = 1'b0;
    stall_s = 1'b0; cyc2_s = 1'b0; fiq_a_s = 1'b0; save_s = 1'b0; pcin_s = 1'b0;
    rmicro_s = 1'b0;
    ack_s    = {NIRQ{1'b0}};
    vec_s    = {VECW{1'b0}};
    tgt_ok_s = 1'b0;
    if (DataAbort) begin
      fl_d_s = 1'b1; fl_e_s = 1'b1; fl_m_s = 1'b1; fl_w_s = 1'b1;
      stall_s = 1'b1; rmicro_s = 1'b1;
      state_d = S_ABORT2;
    end else if (state_q == S_ABORT2) begin
      cyc2_s = 1'b1; fl_d_s = 1'b1; fl_m_s = 1'b1; fl_w_s = 1'b1;
      save_s = 1'b1; pcin_s = 1'b1; vec_s = VECW'(8'h10);
      state_d = S_IDLE;
    end else if (sync_s) begin
      fl_d_s = 1'b1; fl_m_s = 1'b1; save_s = 1'b1; pcin_s = 1'b1;
      vec_s = sync_vec_s;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fiq_el_s || irq_any_s) begin
            tgt_fiq_d = fiq_el_s;
            tgt_irq_d = irq_idx_s;
            clr_f_s   = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DRAIN: begin
          // A fresh FIQ overrides a latched IRQ; the FIQ is then trivially eligible.
          if (fiq_el_s) begin
            tgt_fiq_d = 1'b1;
          end else begin
            tgt_fiq_d = tgt_fiq_q;
          end
          tgt_ok_s = tgt_fiq_d ? fiq_el_s : irq_el_s[tgt_irq_q];
          if (!tgt_ok_s) begin
            state_d = S_IDLE;
          end else begin
            clr_f_s = ~PipelineClearM;
            fl_e_s  = PipelineClearD & ~PipelineClearM;
            stall_s = PipelineClearD & ~PipelineClearM;
            state_d = PipelineClearM ? S_TAKE : S_DRAIN;
          end
        end
        S_TAKE: begin
          fl_d_s = 1'b1;
          save_s = 1'b1;
          if (tgt_fiq_q) begin
            fiq_a_s = 1'b1;
            vec_s   = VECW'(8'h1C);
          end else begin
            for (int k = 0; k < NIRQ; k++) begin
              ack_s[k] = (tgt_irq_q == IDXW'(k));
            end
            vec_s = VECW'(32'h20 + 32'(tgt_irq_q) * 32'd4);
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    if (state_d == S_IDLE || state_d == S_ABORT2) begin
      tgt_fiq_d = 1'b0;
      tgt_irq_d = {IDXW{1'b0}};
    end else begin
      tgt_fiq_d = tgt_fiq_d;
      tgt_irq_d = tgt_irq_d;
    end
  end

  // State and latched-target registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tgt_fiq_q <= 1'b0;
      tgt_irq_q <= {IDXW{1'b0}};
    end else begin
      state_q   <= state_d;
      tgt_fiq_q <= tgt_fiq_d;
      tgt_irq_q <= tgt_irq_d;
    end
  end

  // Outputs respond combinationally to events, so they are forced low while in reset.
  assign PipelineClearF       = reset & clr_f_s;
  assign ExceptionFlushD      = reset & fl_d_s;
  assign ExceptionFlushE      = reset & fl_e_s;
  assign ExceptionFlushM      = reset & fl_m_s;
  assign ExceptionFlushW      = reset & fl_w_s;
  assign ExceptionStallD      = reset & stall_s;
  assign DataAbortCycle2      = reset & cyc2_s;
  assign FIQAssert            = reset & fiq_a_s;
  assign IrqAck               = reset ? ack_s : {NIRQ{1'b0}};
  assign PCVectorAddress      = reset ? vec_s : {VECW{1'b0}};
  assign ExceptionSavePC      = reset & save_s;
  assign PCInSelect           = reset & pcin_s;
  assign ExceptionResetMicrop = reset & rmicro_s;
  assign Busy                 = reset & (state_q != S_IDLE);

endmodule

// File: tb/tb_exception_arbiter.sv
// Randomised bench for exception_arbiter: a rule-level reference model predicts every
// cycle's outputs and queues each taken event for a decoupled monitor to check.
module tb_exception_arbiter;
  localparam int NIRQ = 4;
  localparam int VECW = 8;
  localparam int OW   = 12 + NIRQ + VECW;
  localparam int EW   = VECW + 2 + NIRQ;

  logic clk = 1'b0;
  logic reset, UndefinedInstrE, SWIE, PrefetchAbortE, DataAbort, FIQ, FIQEnabled;
  logic [NIRQ-1:0] IrqReq, IrqEnable, IrqAck;
  logic PipelineClearD, PipelineClearM, PipelineClearF;
  logic ExceptionFlushD, ExceptionFlushE, ExceptionFlushM, ExceptionFlushW, ExceptionStallD;
  logic DataAbortCycle2, FIQAssert, ExceptionSavePC, PCInSelect, ExceptionResetMicrop, Busy;
  logic [VECW-1:0] PCVectorAddress;

  exception_arbiter #(.NIRQ(NIRQ), .VECW(VECW)) dut (
    .clk(clk), .reset(reset), .UndefinedInstrE(UndefinedInstrE), .SWIE(SWIE),
    .PrefetchAbortE(PrefetchAbortE), .DataAbort(DataAbort), .FIQ(FIQ), .FIQEnabled(FIQEnabled),
    .IrqReq(IrqReq), .IrqEnable(IrqEnable), .PipelineClearD(PipelineClearD),
    .PipelineClearM(PipelineClearM), .PipelineClearF(PipelineClearF),
    .ExceptionFlushD(ExceptionFlushD), .ExceptionFlushE(ExceptionFlushE),
    .ExceptionFlushM(ExceptionFlushM), .ExceptionFlushW(ExceptionFlushW),
    .ExceptionStallD(ExceptionStallD), .DataAbortCycle2(DataAbortCycle2),
    .FIQAssert(FIQAssert), .IrqAck(IrqAck), .PCVectorAddress(PCVectorAddress),
    .ExceptionSavePC(ExceptionSavePC), .PCInSelect(PCInSelect),
    .ExceptionResetMicrop(ExceptionResetMicrop), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int takes = 0;
  bit started = 1'b0;
  logic [OW-1:0] exp_vec;
  logic [EW-1:0] evq[$];

  // Model state: mode 0 idle, 1 second abort cycle, 2 draining, 3 taking.
  // Target: -1 none, 0..NIRQ-1 an IRQ channel, NIRQ the FIQ.
  int m_mode = 0;
  int m_tgt  = -1;

  task automatic model_cycle();
    logic clrf, fd, fe, fm, fw, st, c2, fa, sv, pc, rm, bz, ok, fiq_ok;
    logic [NIRQ-1:0] ack;
    logic [VECW-1:0] vec;
    int low, nmode;
    clrf = 0; fd = 0; fe = 0; fm = 0; fw = 0; st = 0; c2 = 0; fa = 0;
    sv = 0; pc = 0; rm = 0; ack = '0; vec = '0;
    bz = (m_mode != 0);
    nmode = 0;
    if (!reset) begin
      m_mode = 0; m_tgt = -1; exp_vec = '0;
      return;
    end
    fiq_ok = FIQ & FIQEnabled;
    low = -1;
    for (int i = NIRQ - 1; i >= 0; i--) if (IrqReq[i] & IrqEnable[i]) low = i;
    if (DataAbort) begin
      fd = 1; fe = 1; fm = 1; fw = 1; st = 1; rm = 1; nmode = 1; m_tgt = -1;
    end else if (m_mode == 1) begin
      c2 = 1; fd = 1; fm = 1; fw = 1; sv = 1; pc = 1; vec = 8'h10;
    end else if (PrefetchAbortE | UndefinedInstrE | SWIE) begin
      fd = 1; fm = 1; sv = 1; pc = 1;
      vec = PrefetchAbortE ? 8'h0C : (UndefinedInstrE ? 8'h04 : 8'h08);
    end else if (m_mode == 0) begin
      if (fiq_ok) m_tgt = NIRQ; else m_tgt = low;
      if (m_tgt >= 0) begin clrf = 1; nmode = 2; end
    end else if (m_mode == 2) begin
      if (fiq_ok) m_tgt = NIRQ;
      ok = (m_tgt == NIRQ) ? fiq_ok : (IrqReq[m_tgt] & IrqEnable[m_tgt]);
      if (ok) begin
        clrf = ~PipelineClearM;
        fe = PipelineClearD & ~PipelineClearM;
        st = fe;
        nmode = PipelineClearM ? 3 : 2;
      end
    end else begin
      fd = 1; sv = 1;
      if (m_tgt == NIRQ) begin fa = 1; vec = 8'h1C; end
      else begin ack[m_tgt] = 1'b1; vec = VECW'(8'h20 + 4 * m_tgt); end
    end
    m_mode = nmode;
    if (nmode == 0 || nmode == 1) m_tgt = -1;
    exp_vec = {clrf, fd, fe, fm, fw, st, c2, fa, ack, vec, sv, pc, rm, bz};
    if (sv) evq.push_back({vec, pc, fa, ack});
  endtask

  task automatic step(input logic rs, da, pa, ui, sw, fq, fen,
                      input logic [NIRQ-1:0] irq, ien, input logic cd, cm);
    @(posedge clk);
    #1;
    reset = rs; DataAbort = da; PrefetchAbortE = pa; UndefinedInstrE = ui; SWIE = sw;
    FIQ = fq; FIQEnabled = fen; IrqReq = irq; IrqEnable = ien;
    PipelineClearD = cd; PipelineClearM = cm;
    model_cycle();
    started = 1'b1;
  endtask

  // Monitor: every-cycle output comparison plus taken-event scoreboard.
  always @(negedge clk) begin
    logic [OW-1:0] got;
    logic [EW-1:0] ev, exp_ev;
    if (started) begin
      got = {PipelineClearF, ExceptionFlushD, ExceptionFlushE, ExceptionFlushM,
             ExceptionFlushW, ExceptionStallD, DataAbortCycle2, FIQAssert, IrqAck,
             PCVectorAddress, ExceptionSavePC, PCInSelect, ExceptionResetMicrop, Busy};
      checks++;
      if (got !== exp_vec) begin
        failures++;
        $display("FAIL outputs t=%0t actual=%h required=%h", $time, got, exp_vec);
      end
      if (ExceptionSavePC === 1'b1) begin
        ev = {PCVectorAddress, PCInSelect, FIQAssert, IrqAck};
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL take_event t=%0t actual=%h required=none", $time, ev);
        end else begin
          exp_ev = evq.pop_front();
          takes++;
          if (ev !== exp_ev) begin
            failures++;
            $display("FAIL take_event t=%0t actual=%h required=%h", $time, ev, exp_ev);
          end
        end
      end
    end
  end

  initial begin
    logic [NIRQ-1:0] irq, ien;
    logic fq;
    reset = 0; DataAbort = 0; PrefetchAbortE = 0; UndefinedInstrE = 0; SWIE = 0;
    FIQ = 0; FIQEnabled = 0; IrqReq = '0; IrqEnable = '0; PipelineClearD = 0; PipelineClearM = 0;
    step(0, 1, 1, 0, 0, 1, 1, 4'hF, 4'hF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    // Data abort pulse, then abort together with an undefined instruction.
    step(1, 1, 0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 0);
    // IRQ 1 and 2 pending: drain, then take channel 1.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 4'b0110, 4'hF, i[0], 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0110, 4'hF, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 0, 0);
    // IRQ 2 draining, FIQ arrives and takes over.
    step(1, 0, 0, 0, 0, 0, 0, 4'b0100, 4'hF, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 4'b0100, 4'hF, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 4'b0100, 4'hF, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 0, 0);
    // SWI during drain, IRQ still high restarts the drain.
    step(1, 0, 0, 0, 0, 0, 0, 4'b1000, 4'hF, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 4'b1000, 4'hF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'b1000, 4'hF, 0, 0);
    // Request masked mid-drain, then reset mid-drain.
    step(1, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0001, 4'hF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'hF, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 0, 0);
    irq = '0; ien = 4'hF; fq = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) irq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) ien = 4'($urandom) | 4'b0011;
      if ($urandom_range(0, 9) == 0) fq = ~fq;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 59) == 0),
           fq, ($urandom_range(0, 3) != 0), irq, ien,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    step(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    @(posedge clk);
    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL pending_events actual=%0d required=0", evq.size());
    end
    checks++;
    if (takes < 20) begin
      failures++;
      $display("FAIL take_count actual=%0d required>=20", takes);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
